// File: rtl/i4003_loader.sv
// Serializer that loads a chain of i4003 shift registers MSB first and
// captures the chain's returning serial output as read-back of the prior contents.
module i4003_loader #(
  parameter int SYSCLK_TCY         = 20,
  parameter int WIDTH              = 10,
  parameter int CP_LOW_NS          = 500,
  parameter int CP_HIGH_NS         = 500,
  parameter int BLANK_DURING_SHIFT = 1
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             cp,
  output logic             sr_data,
  input  logic             sr_return,
  output logic             enable,
  output logic [WIDTH-1:0] readback_data,
  output logic             done
);

  localparam int LOW_CY  = (CP_LOW_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int HIGH_CY = (CP_HIGH_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
  localparam int CNT_MAX = (LOW_CY > HIGH_CY) ? LOW_CY : HIGH_CY;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int K_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CY - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CY - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_TAIL} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [K_W-1:0]   k, k_n;
  logic [WIDTH-1:0] sbuf, sbuf_n;
  logic [WIDTH-1:0] rb_shift, rb_shift_n;
  logic [WIDTH-1:0] readback_n;
  logic             cp_n, sr_data_n, enable_n, done_n;

  assign load_ready = (state == S_IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CNT_W'(1);
    k_n        = k;
    sbuf_n     = sbuf;
    rb_shift_n = rb_shift;
    readback_n = readback_data;
    enable_n   = enable;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (load_valid) begin
          sbuf_n  = load_data;
          k_n     = '0;
          state_n = S_LOW;
          if (BLANK_DURING_SHIFT != 0) enable_n = 1'b0;
        end
      end
      S_LOW: begin
        if (cnt == LOW_LAST) begin
          // Shifting in MSB first leaves the first sample in bit WIDTH-1.
          rb_shift_n = {rb_shift[WIDTH-2:0], sr_return};
          cnt_n      = '0;
          state_n    = S_HIGH;
        end
      end
      S_HIGH: begin
        if (cnt == HIGH_LAST) begin
          cnt_n  = '0;
          sbuf_n = {sbuf[WIDTH-2:0], 1'b0};
          if (k == K_LAST) begin
            state_n = S_TAIL;
          end else begin
            k_n     = k + K_W'(1);
            state_n = S_LOW;
          end
        end
      end
      S_TAIL: begin
        if (cnt == LOW_LAST) begin
          cnt_n      = '0;
          done_n     = 1'b1;
          enable_n   = 1'b1;
          readback_n = rb_shift;
          state_n    = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // cp and sr_data are registered from next-state values so they are glitch-free.
    cp_n      = (state_n == S_HIGH);
    sr_data_n = ((state_n == S_LOW) || (state_n == S_HIGH)) ? sbuf_n[WIDTH-1] : 1'b0;
  end

  always_ff @(posedge sysclk) begin
    if (!sysreset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      k             <= '0;
      sbuf          <= '0;
      rb_shift      <= '0;
      readback_data <= '0;
      cp            <= 1'b0;
      sr_data       <= 1'b0;
      enable        <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      k             <= k_n;
      sbuf          <= sbuf_n;
      rb_shift      <= rb_shift_n;
      readback_data <= readback_n;
      cp            <= cp_n;
      sr_data       <= sr_data_n;
      enable        <= enable_n;
      done          <= done_n;
    end
  end

endmodule
